// File: rtl/train_if.sv
`default_nettype none
// ============================================================================
// Module   : train_if
// Purpose  : Bundles the track-sensor inputs and the 7-segment display
//            outputs of the train-track block controller.
// Signals  : S1..S6 - track sensors (S1/S2 block A, S3/S4 block B,
//                     S5/S6 block C; odd = entry, even = exit), active-high
//            an     - 4 digit enables, active-low, one-hot, an[0] rightmost
//            seg7   - segments {g,f,e,d,c,b,a}, active-low
// Modports : master - sensor/board side (drives S*, observes display)
//            slave  - controller side (samples S*, drives display)
// Revision : 1.0 - initial release
// ============================================================================
interface train_if;
  logic       S1;
  logic       S2;
  logic       S3;
  logic       S4;
  logic       S5;
  logic       S6;
  logic [3:0] an;
  logic [6:0] seg7;

  modport master (output S1, S2, S3, S4, S5, S6, input an, seg7);
  modport slave  (input S1, S2, S3, S4, S5, S6, output an, seg7);
endinterface
`default_nettype wire

// File: rtl/train_controller_top.sv
`default_nettype none
// ============================================================================
// Module   : train_controller_top
// Purpose  : Train-track block controller. Three blocks (A: S1/S2,
//            B: S3/S4, C: S5/S6) are tracked as FREE / OCCUPIED / CLEARING
//            with a sticky FAULT on an exit seen while FREE. Status and the
//            occupied-block count are shown on a 4-digit multiplexed
//            common-anode 7-segment display.
// Ports    : clk  - system clock, rising edge
//            rst  - synchronous reset, active-high
//            bus  - train_if.slave: S1..S6 in, an[3:0] / seg7[6:0] out
// Params   : DIGIT_CYCLES    - clk cycles per digit scan slot (>=2)
//            DEBOUNCE_CYCLES - stable samples needed to accept a level
//                              change (only with DEBOUNCE_EN)
// Options  : DEBOUNCE_EN - when defined, a debounce filter follows the
//            synchronizer (pin-to-state latency 3+DEBOUNCE_CYCLES).
// Revision : 1.0 - initial release
// ============================================================================
module train_controller_top #(
  parameter int DIGIT_CYCLES    = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic   clk,
  input  logic   rst,
  train_if.slave bus
);

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_OCC  = 2'd1,
    ST_CLR  = 2'd2
  } blk_state_t;

  localparam logic [6:0] c_SEG_F     = 7'b0001110;
  localparam logic [6:0] c_SEG_E     = 7'b0000110;
  localparam logic [6:0] c_SEG_0     = 7'b1000000;
  localparam logic [6:0] c_SEG_1     = 7'b1111001;
  localparam logic [6:0] c_SEG_2     = 7'b0100100;
  localparam logic [6:0] c_SEG_3     = 7'b0110000;
  localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

  localparam int                c_DW_W       = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [c_DW_W-1:0] c_DWELL_LAST = c_DW_W'(DIGIT_CYCLES - 1);

  // Edges are suppressed until the input pipeline has fully refilled after
  // reset, so a sensor held high across reset does not look like a new rise.
`ifdef DEBOUNCE_EN
  localparam int c_WARM_CYC = 3 + DEBOUNCE_CYCLES;
`else
  localparam int c_WARM_CYC = 3;
`endif
  localparam int                  c_WARM_W = $clog2(4 + DEBOUNCE_CYCLES);
  localparam logic [c_WARM_W-1:0] c_WARM   = c_WARM_W'(c_WARM_CYC);

  // --------------------------------------------------------------------------
  // Sensor path: 2-flop synchronizer, optional debounce, edge detect
  // Bit order: [0]=S1 ... [5]=S6; block n uses entry 2n, exit 2n+1.
  // --------------------------------------------------------------------------
  logic [5:0]          w_pin;
  logic [5:0]          r_sync1;
  logic [5:0]          r_sync2;
  logic [5:0]          w_lvl;
  logic [5:0]          r_prev;
  logic [5:0]          w_rise;
  logic [5:0]          w_fall;
  logic [c_WARM_W-1:0] r_warm;
  logic                w_armed;

  assign w_pin = {bus.S6, bus.S5, bus.S4, bus.S3, bus.S2, bus.S1};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_pin;
      r_sync2 <= r_sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int                c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_db
      logic [c_DB_W-1:0] r_cnt;
      logic              r_stable;

      // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt    <= '0;
          r_stable <= 1'b0;
        end else if (r_sync2[gi] == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DB_LAST) begin
          r_cnt    <= '0;
          r_stable <= r_sync2[gi];
        end else begin
          r_cnt <= r_cnt + c_DB_W'(1);
        end
      end

      assign w_lvl[gi] = r_stable;
    end
  endgenerate
`else
  assign w_lvl = r_sync2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
      r_warm <= '0;
    end else begin
      r_prev <= w_lvl;
      if (r_warm != c_WARM) begin
        r_warm <= r_warm + c_WARM_W'(1);
      end
    end
  end

  assign w_armed = (r_warm == c_WARM);
  assign w_rise  =  w_lvl & ~r_prev & {6{w_armed}};
  assign w_fall  = ~w_lvl &  r_prev & {6{w_armed}};

  // --------------------------------------------------------------------------
  // Per-block state machines
  // --------------------------------------------------------------------------
  logic [2:0] w_busy;
  logic [2:0] w_fault;

  generate
    for (genvar gb = 0; gb < 3; gb++) begin : g_blk
      blk_state_t r_state;
      blk_state_t w_state_nx;
      logic       r_fault;
      logic       w_fault_nx;
      logic       w_ent_rise;
      logic       w_ext_rise;
      logic       w_ext_fall;

      assign w_ent_rise = w_rise[2*gb];
      assign w_ext_rise = w_rise[2*gb+1];
      assign w_ext_fall = w_fall[2*gb+1];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_state <= ST_FREE;
          r_fault <= 1'b0;
        end else begin
          r_state <= w_state_nx;
          r_fault <= w_fault_nx;
        end
      end

      always_comb begin
        w_state_nx = r_state;
        w_fault_nx = r_fault;
        case (r_state)
          // Entry wins over a coincident exit rise: no fault in that case.
          ST_FREE: begin
            if (w_ent_rise)      w_state_nx = ST_OCC;
            else if (w_ext_rise) w_fault_nx = 1'b1;
          end
          ST_OCC: begin
            if (w_ext_rise) w_state_nx = ST_CLR;
          end
          // A new train takes priority over the previous one leaving.
          ST_CLR: begin
            if (w_ent_rise)      w_state_nx = ST_OCC;
            else if (w_ext_fall) w_state_nx = ST_FREE;
          end
          default: w_state_nx = ST_FREE;
        endcase
      end

      assign w_busy[gb]  = (r_state != ST_FREE);
      assign w_fault[gb] = r_fault;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Display scan
  // --------------------------------------------------------------------------
  logic [1:0]        w_count;
  logic [6:0]        w_glyph;
  logic [c_DW_W-1:0] r_dwell;
  logic [1:0]        r_digit;
  logic [3:0]        r_an;
  logic [6:0]        r_seg;

  assign w_count = {1'b0, w_busy[0]} + {1'b0, w_busy[1]} + {1'b0, w_busy[2]};

  function automatic logic [6:0] blk_glyph(input logic busy, input logic fault);
    if (fault)     return c_SEG_E;
    else if (busy) return c_SEG_0;
    else           return c_SEG_F;
  endfunction

  always_comb begin
    w_glyph = c_SEG_BLANK;
    case (r_digit)
      2'd0: w_glyph = blk_glyph(w_busy[0], w_fault[0]);
      2'd1: w_glyph = blk_glyph(w_busy[1], w_fault[1]);
      2'd2: w_glyph = blk_glyph(w_busy[2], w_fault[2]);
      default: begin
        case (w_count)
          2'd0:    w_glyph = c_SEG_0;
          2'd1:    w_glyph = c_SEG_1;
          2'd2:    w_glyph = c_SEG_2;
          default: w_glyph = c_SEG_3;
        endcase
      end
    endcase
  end

  // an and seg7 are loaded together from the digit being scanned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dwell <= '0;
      r_digit <= 2'd0;
      r_an    <= 4'b1111;
      r_seg   <= c_SEG_BLANK;
    end else begin
      r_an  <= ~(4'b0001 << r_digit);
      r_seg <= w_glyph;
      if (r_dwell == c_DWELL_LAST) begin
        r_dwell <= '0;
        r_digit <= r_digit + 2'd1;
      end else begin
        r_dwell <= r_dwell + c_DW_W'(1);
      end
    end
  end

  assign bus.an   = r_an;
  assign bus.seg7 = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_train_controller_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_train_controller_top
// Purpose  : Directed self-checking bench for train_controller_top.
//            Drives sensors on the falling clock edge and samples the
//            display on the falling edge. Honours DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_train_controller_top;

`ifdef DEBOUNCE_EN
  localparam int c_LAT = 7;
`else
  localparam int c_LAT = 3;
`endif

  localparam logic [6:0] c_F  = 7'b0001110;
  localparam logic [6:0] c_E  = 7'b0000110;
  localparam logic [6:0] c_D0 = 7'b1000000;
  localparam logic [6:0] c_D1 = 7'b1111001;
  localparam logic [6:0] c_D3 = 7'b0110000;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  train_if bus ();

  train_controller_top #(
    .DIGIT_CYCLES   (16),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns on the first falling edge after digit d has freshly been loaded.
  task automatic wait_fresh(input int d, input string tag);
    logic [3:0] want;
    int         n;
    want = ~(4'b0001 << d);
    n    = 0;
    while (bus.an === want && n < 200) begin
      @(negedge clk);
      n++;
    end
    while (bus.an !== want && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_an"}, 32'(bus.an), 32'(want));
  endtask

  task automatic see(input int d, input logic [6:0] exp_seg, input string tag);
    wait_fresh(d, tag);
    chk(tag, 32'(bus.seg7), 32'(exp_seg));
  endtask

  task automatic set_s(input logic [5:0] v);
    {bus.S6, bus.S5, bus.S4, bus.S3, bus.S2, bus.S1} = v;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    set_s(6'b000000);

    // Reset state
    cyc(2);
    chk("rst_an", 32'(bus.an), 32'(4'b1111));
    chk("rst_seg", 32'(bus.seg7), 32'(7'b1111111));
    rst = 1'b0;
    cyc(1);
    chk("first_an", 32'(bus.an), 32'(4'b1110));
    chk("first_seg", 32'(bus.seg7), 32'(c_F));
    cyc(15);
    chk("dwell_end_an", 32'(bus.an), 32'(4'b1110));
    cyc(1);
    chk("dwell_next_an", 32'(bus.an), 32'(4'b1101));
    see(1, c_F, "idle_d1");
    see(2, c_F, "idle_d2");
    see(3, c_D0, "idle_d3");
    see(0, c_F, "idle_d0");

    // Block A: entry with exact latency, exit, exit fall with exact latency
    wait_fresh(0, "a_sync");
    set_s(6'b000001);
    cyc(c_LAT);
    chk("a_occ_early", 32'(bus.seg7), 32'(c_F));
    cyc(1);
    chk("a_occ", 32'(bus.seg7), 32'(c_D0));
    see(3, c_D1, "a_cnt1");
    set_s(6'b000011);
    cyc(c_LAT + 2);
    see(0, c_D0, "a_clr");
    see(3, c_D1, "a_clr_cnt");
    wait_fresh(0, "a_sync2");
    set_s(6'b000000);
    cyc(c_LAT);
    chk("a_free_early", 32'(bus.seg7), 32'(c_D0));
    cyc(1);
    chk("a_free", 32'(bus.seg7), 32'(c_F));
    see(3, c_D0, "a_cnt0");

    // Block B: full pass, no fault
    set_s(6'b000100);
    cyc(10);
    see(1, c_D0, "b_occ");
    set_s(6'b001100);
    cyc(10);
    see(1, c_D0, "b_clr");
    set_s(6'b000000);
    cyc(10);
    see(1, c_F, "b_free");
    see(3, c_D0, "b_cnt0");

    // Block C: exit pulse while FREE latches fault
    set_s(6'b100000);
    cyc(8);
    set_s(6'b000000);
    cyc(10);
    see(2, c_E, "c_fault");
    see(0, c_F, "c_fault_a");
    see(1, c_F, "c_fault_b");

    // All three entries: count 3, fault still has display priority
    set_s(6'b010101);
    cyc(10);
    see(3, c_D3, "cnt3");
    see(2, c_E, "c_fault_pri");
    see(0, c_D0, "all_a");
    see(1, c_D0, "all_b");

    // Reset mid-train with sensors held high: no spurious rises afterwards
    rst = 1'b1;
    cyc(2);
    chk("rst2_an", 32'(bus.an), 32'(4'b1111));
    rst = 1'b0;
    cyc(1);
    chk("rst2_first_seg", 32'(bus.seg7), 32'(c_F));
    cyc(20);
    see(0, c_F, "held_a");
    see(2, c_F, "held_c");
    see(3, c_D0, "held_cnt");
    set_s(6'b000000);
    cyc(10);

    // Simultaneous entry/exit rise while FREE
    set_s(6'b000011);
    cyc(10);
    see(0, c_D0, "sim_a");
    see(3, c_D1, "sim_cnt");
    set_s(6'b000000);
    cyc(10);
    see(0, c_D0, "sim_a_hold");

    // Short S3 pulse
    set_s(6'b000100);
    cyc(2);
    set_s(6'b000000);
    cyc(12);
`ifdef DEBOUNCE_EN
    see(1, c_F, "glitch_b");
`else
    see(1, c_D0, "glitch_b");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
